// File: rtl/counter_seq_pkg.sv
// Shared encodings for the counter sequencer: FSM states and mode values.
package counter_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// WIDTH-bit up-counter that sticks at all-ones; synchronous reset and clear.
module sat_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1'b1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/counter_sequencer.sv
// Sequences an external enable/clear counter from 0 up to a latched terminal value,
// in one-shot or auto-reload mode, with pause, abort and a completed-period count.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             mode,
    input  logic [WIDTH-1:0] terminal,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             cnt_enable,
    output logic             cnt_clear_n,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] period_count
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] term_q, term_d;
    logic             mode_q, mode_d;
    logic             err_q, err_d;
    logic             accept;
    logic             at_term;

    assign at_term = (cnt_q == term_q);

    always_comb begin
        state_d     = state_q;
        term_d      = term_q;
        mode_d      = mode_q;
        err_d       = 1'b0;
        accept      = 1'b0;
        cnt_enable  = 1'b0;
        cnt_clear_n = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        unique case (state_q)
            IDLE: begin
                // stop outranks a simultaneous start
                if (start && !stop) begin
                    if (terminal != '0) begin
                        accept  = 1'b1;
                        term_d  = terminal;
                        mode_d  = mode;
                        state_d = CLR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            CLR: begin
                busy    = 1'b1;
                state_d = stop ? IDLE : RUN;
            end
            RUN: begin
                busy        = 1'b1;
                cnt_clear_n = 1'b1;
                cnt_enable  = !at_term && !pause;
                if (stop) begin
                    state_d = IDLE;
                end else if (at_term) begin
                    done    = 1'b1;
                    state_d = (mode_q == MODE_PERIODIC) ? CLR : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A reset landing on the terminal cycle must not report completion.
        if (clear) begin
            done = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= IDLE;
            term_q  <= '0;
            mode_q  <= MODE_ONESHOT;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            term_q  <= term_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
        end
    end

    assign err = err_q;

    sat_counter #(
        .WIDTH(WIDTH)
    ) u_period (
        .clk  (clk),
        .rst  (clear),
        .clr  (accept),
        .inc  (done),
        .count(period_count)
    );

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Controller that sequences a WIDTH-bit enable counter: a 4-bit JK-chain counter with `enable` and active-low `clear`.
- Turns a one-cycle start command into a timed count from 0 up to a programmed terminal value, then asserts done.
- Runs in one-shot or periodic (auto-reload) mode, supports pause and abort, and counts completed periods.
- Sits between the control logic and the counter instance; it is the only driver of the counter's `enable` and `clear`.

Parameters:
- WIDTH, 4, width of the counter being sequenced, of `terminal`, and of `period_count`.

Ports:
- clk  input  1  system clock, rising edge.
- clear  input  1  reset; synchronous and active-high.
- start  input  1  one-cycle command; sampled only in IDLE.
- stop  input  1  abort; returns to IDLE from any state.
- pause  input  1  level; freezes counting while high in RUN.
- mode  input  1  0 = one-shot, 1 = periodic; latched on accepted start.
- terminal  input  WIDTH  terminal count; latched on accepted start.
- cnt_q  input  WIDTH  current value of the counter.
- cnt_enable  output  1  drives the counter's `enable`.
- cnt_clear_n  output  1  drives the counter's active-low `clear`.
- busy  output  1  high in CLR and RUN.
- done  output  1  one-cycle pulse when cnt_q reaches the terminal count.
- err  output  1  one-cycle pulse when start is rejected.
- period_count  output  WIDTH  number of completed periods since the last accepted start.

Behaviour:
- Counter model: on each clk edge the counter increments when cnt_enable=1 and cnt_clear_n=1, and loads 0 when cnt_clear_n=0.
- Reset (clear=1 at an edge):
  - state=IDLE, term_r=0, mode_r=0, period_count=0.
  - Outputs: cnt_enable=0, cnt_clear_n=0, busy=0, done=0, err=0.
  - Reset mid-run takes effect on that edge with no done pulse.
- States (encoding in package): IDLE, CLR, RUN.
- IDLE:
  - cnt_clear_n=0, cnt_enable=0.
  - start=1 and terminal!=0: latch term_r and mode_r, set period_count=0, next state CLR.
  - start=1 and terminal==0: err=1 for the next cycle, stay IDLE.
- CLR (exactly one cycle):
  - cnt_clear_n=0, cnt_enable=0, busy=1, next state RUN.
- RUN:
  - cnt_clear_n=1, busy=1.
  - cnt_enable is combinational: (cnt_q!=term_r) & ~pause.
  - When cnt_q==term_r, done=1 (combinational, one cycle) and period_count increments, saturating at 2^WIDTH-1.
  - Next state after done: CLR if mode_r=1, otherwise IDLE.
- Timing:
  - done occurs term_r+1 cycles after CLR when pause is never asserted.
  - Periodic mode repeats every term_r+2 cycles.
  - Each cycle of pause extends this by one cycle; cnt_q holds during pause.
- Bounds: term_r caps the count, so cnt_q never wraps; term_r = 2^WIDTH-1 is legal.
- Priority and edge cases:
  - stop=1 forces next state IDLE from CLR or RUN, suppresses done that cycle, and leaves period_count unchanged.
  - stop and start in the same cycle: stop wins.
  - start outside IDLE is ignored; term_r and mode_r do not change.
  - pause and cnt_q==term_r in the same cycle: done still fires.
  - pause in CLR has no effect.
- Outputs done and err never overlap.

Decomposition:
- Package counter_seq_pkg holds the state encoding constants (IDLE=2'd0, CLR=2'd1, RUN=2'd2) and the mode constants (MODE_ONESHOT=0, MODE_PERIODIC=1).
- One sub-module: sat_counter, a WIDTH-bit saturating counter with synchronous clear and increment, used for period_count.
- The FSM and compare logic stay in counter_sequencer.

Test Plan:
- One-shot: terminal=5, mode=0, start pulse → CLR for 1 cycle; cnt_q runs 0..5; done pulses 6 cycles after CLR; IDLE next cycle; period_count=1; cnt_clear_n=0 again.
- Periodic with saturation: terminal=3, mode=1 → done every 5 cycles; let it run 20 periods → period_count saturates at 15; busy stays 1 throughout.
- Pause: terminal=4; hold pause for 3 cycles while cnt_q=2 → cnt_q holds at 2; done is delayed by 3 cycles (8 cycles after CLR).
- Stop mid-run: terminal=9, stop at cnt_q=6 → IDLE next cycle; no done; cnt_q=0 after the following edge; start and stop together in the same cycle are ignored (stop wins).
- Rejected start: terminal=0 → err pulses for 1 cycle; busy stays 0.
- Reset mid-run: clear=1 while in RUN → all outputs at reset values on the next edge; then terminal=15 one-shot → done 16 cycles after CLR with no wrap.
